// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - arbitrates two requesters onto one shared ALU/shifter
//
// Purpose: picks one of two requesters (0 = execute stage, 1 = aux/debug),
// latches its operands into the ALU input registers, captures the ALU result
// and SZCV one cycle later, maintains the architectural flag register and
// returns the response to the owning requester over a valid/ready handshake.
//
// Build option: ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins
// contention; otherwise contention is resolved round-robin.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready [1:0]      request handshake, one bit per requester
//   req_op/req_shd [7:0]           {r1, r0} 4-bit opcode / shift distance
//   req_a/req_b [31:0]             {r1, r0} 16-bit operands
//   rsp_valid/rsp_ready [1:0]      response handshake, one-hot to owner
//   rsp_res [15:0], rsp_szcv [3:0] captured result and SZCV
//   alu_op/alu_a/alu_b/alu_shift_d registered drive to the external ALU
//   alu_res, alu_szcv              combinational return from the external ALU
//   flags [3:0]                    architectural SZCV register
//   busy                           high whenever a transaction is in flight

module alu_share_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [4*NREQ-1:0]   req_shd,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [W-1:0]        rsp_res,
  output logic [3:0]          rsp_szcv,
  output logic [3:0]          alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [3:0]          alu_shift_d,
  input  logic [W-1:0]        alu_res,
  input  logic [3:0]          alu_szcv,
  output logic [3:0]          flags,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic         last_grant;
  logic         owner;
  logic         grant;
  logic         accept;
  logic         op_arith;
  logic         op_logic;
  logic [3:0]   op_q;
  logic [3:0]   shd_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] res_q;
  logic [3:0]   szcv_q;
  logic [3:0]   flags_q;

  // Grant selection; only meaningful while IDLE with at least one valid.
  always_comb begin
    grant = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  // Opcode classes: arithmetic writes all of SZCV, logic/move/shift writes
  // only S and Z, anything else is illegal and produces a zero response.
  always_comb begin
    op_arith = 1'b0;
    op_logic = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0101: op_arith = 1'b1;
      4'b0010, 4'b0011, 4'b0100, 4'b0110,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: op_logic = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept           = 1'b1;
          req_ready[grant] = 1'b1;
          state_nx         = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Nothing may be handshaken while reset is asserted.
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shd_q      <= '0;
      res_q      <= '0;
      szcv_q     <= '0;
      flags_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= grant;
        owner      <= grant;
        op_q       <= grant ? req_op[7:4]       : req_op[3:0];
        shd_q      <= grant ? req_shd[7:4]      : req_shd[3:0];
        a_q        <= grant ? req_a[2*W-1:W]    : req_a[W-1:0];
        b_q        <= grant ? req_b[2*W-1:W]    : req_b[W-1:0];
      end
      if (state == EXEC) begin
        if (op_arith || op_logic) begin
          res_q  <= alu_res;
          szcv_q <= alu_szcv;
        end else begin
          res_q  <= '0;
          szcv_q <= '0;
        end
        if (op_arith) begin
          flags_q <= alu_szcv;
        end else if (op_logic) begin
          flags_q[3:2] <= alu_szcv[3:2];
        end
      end
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_shift_d = shd_q;
  assign rsp_res     = res_q;
  assign rsp_szcv    = szcv_q;
  assign flags       = flags_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op, req_shd;
  logic [31:0] req_a, req_b;
  logic [15:0] rsp_res, alu_a, alu_b, alu_res;
  logic [3:0]  rsp_szcv, alu_op, alu_shift_d, alu_szcv, flags;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
  } req_t;

  typedef struct {
    int          rq;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
    logic [15:0] res;
    logic [3:0]  szcv;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[12];
  req_t q0[$];
  req_t q1[$];
  int   glog[$];
  int   m_last;
  logic [3:0] m_flags;

  alu_share_arbiter #(.W(16), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shd(req_shd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_szcv(rsp_szcv),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shift_d(alu_shift_d),
    .alu_res(alu_res), .alu_szcv(alu_szcv),
    .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU stand-in. SUB/CMP compute b - a; C is carry (ADD) or
  // borrow (SUB/CMP); non-arithmetic ops report C = V = 0; illegal opcodes
  // return junk so the zeroing of the response is observable.
  function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] d);
    logic [16:0] t;
    logic [15:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; t = '0;
    case (op)
      4'h0: begin
        t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h1, 4'h5: begin
        t = {1'b0, b} - {1'b0, a}; r = t[15:0]; c = t[16];
        v = (a[15] != b[15]) && (r[15] != b[15]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h6: r = b;
      4'h8: r = a << d;
      4'h9: r = a >> d;
      4'hA: r = $signed(a) >>> d;
      4'hB: r = (a << d) | (a >> (16 - d));
      default: return {16'hDEAD, 4'hF};
    endcase
    return {r, r[15], (r == 16'h0), c, v};
  endfunction

  always_comb {alu_res, alu_szcv} = alu_model(alu_op, alu_a, alu_b, alu_shift_d);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int rq);
    return (rq == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic req_t junk();
    req_t r;
    r.op = 4'($urandom); r.a = 16'($urandom); r.b = 16'($urandom); r.d = 4'($urandom);
    return r;
  endfunction

  task automatic drive_slot(input int rq, input req_t r);
    if (rq == 0) begin
      req_op[3:0] = r.op; req_a[15:0] = r.a; req_b[15:0] = r.b; req_shd[3:0] = r.d;
    end else begin
      req_op[7:4] = r.op; req_a[31:16] = r.a; req_b[31:16] = r.b; req_shd[7:4] = r.d;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated transaction with cycle-accurate checks at T, T+1, T+2, T+3.
  task automatic apply_one(input vec_t v);
    req_t r;
    r.op = v.op; r.a = v.a; r.b = v.b; r.d = v.d;
    @(negedge clk);
    #1 check("pre_idle_busy", busy, 1'b0);
    drive_slot(v.rq, r);
    drive_slot(1 - v.rq, junk());
    req_valid = onehot(v.rq);
    rsp_ready = 2'b11;
    #1 check("accept_ready", req_ready, onehot(v.rq));
    @(negedge clk);
    req_valid = 2'b00;
    drive_slot(0, junk()); drive_slot(1, junk());
    #1;
    check("exec_busy", busy, 1'b1);
    check("exec_rsp_valid", rsp_valid, 2'b00);
    check("exec_req_ready", req_ready, 2'b00);
    check("exec_alu_op", alu_op, v.op);
    check("exec_alu_a", alu_a, v.a);
    check("exec_alu_b", alu_b, v.b);
    check("exec_alu_d", alu_shift_d, v.d);
    @(negedge clk);
    #1;
    check("resp_valid", rsp_valid, onehot(v.rq));
    check("resp_res", rsp_res, v.res);
    check("resp_szcv", rsp_szcv, v.szcv);
    check("resp_flags", flags, v.flg);
    check("resp_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    check("post_busy", busy, 1'b0);
    check("post_rsp_valid", rsp_valid, 2'b00);
  endtask

  // Transaction-level reference: drains q0/q1 through the DUT, predicting
  // each grant from the arbitration rule and each response from the ALU
  // function plus the flag-update rules.
  task automatic run_engine(input bit rand_ready, input int max_cycles);
    int         cyc, g, out_rq, acc_cyc;
    bit         out_v;
    req_t       r;
    logic [19:0] e;
    logic [15:0] e_res;
    logic [3:0]  e_szcv, e_flags;
    cyc = 0; out_v = 0; out_rq = 0; acc_cyc = 0;
    e_res = '0; e_szcv = '0; e_flags = '0;
    while ((q0.size() > 0 || q1.size() > 0 || out_v) && cyc < max_cycles) begin
      @(negedge clk);
      req_valid = {q1.size() > 0, q0.size() > 0};
      drive_slot(0, (q0.size() > 0) ? q0[0] : junk());
      drive_slot(1, (q1.size() > 0) ? q1[0] : junk());
      rsp_ready = rand_ready ? 2'($urandom_range(0, 3)) : 2'b11;
      #1;
      if (req_ready != 2'b00) glog.push_back((req_ready == 2'b10) ? 1 : 0);
      if (!out_v && req_valid != 2'b00) begin
        if (q0.size() > 0 && q1.size() > 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          g = 0;
`else
          g = (m_last == 0) ? 1 : 0;
`endif
        end else begin
          g = (q0.size() > 0) ? 0 : 1;
        end
        check("eng_grant", req_ready, onehot(g));
        r = (g == 0) ? q0.pop_front() : q1.pop_front();
        e = alu_model(r.op, r.a, r.b, r.d);
        if (r.op inside {4'h0, 4'h1, 4'h5}) begin
          e_res = e[19:4]; e_szcv = e[3:0]; m_flags = e[3:0];
        end else if (r.op inside {4'h2, 4'h3, 4'h4, 4'h6, [4'h8:4'hB]}) begin
          e_res = e[19:4]; e_szcv = e[3:0]; m_flags = {e[3:2], m_flags[1:0]};
        end else begin
          e_res = '0; e_szcv = '0;
        end
        e_flags = m_flags;
        m_last = g; out_v = 1; out_rq = g; acc_cyc = cyc;
      end else begin
        check("eng_no_ready", req_ready, 2'b00);
      end
      if (out_v && cyc >= acc_cyc + 2) begin
        check("eng_rsp_valid", rsp_valid, onehot(out_rq));
        check("eng_rsp_res", rsp_res, e_res);
        check("eng_rsp_szcv", rsp_szcv, e_szcv);
        check("eng_flags", flags, e_flags);
        if (rsp_ready[out_rq]) out_v = 0;
      end else begin
        check("eng_rsp_quiet", rsp_valid, 2'b00);
      end
      cyc++;
    end
    check("eng_drain", q0.size() + q1.size() + int'(out_v), 0);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    req_t r;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0; req_shd = '0;

    vecs[0]  = '{0, 4'h0, 16'h0003, 16'h0004, 4'h0, 16'h0007, 4'b0000, 4'b0000};
    vecs[1]  = '{1, 4'h1, 16'h0001, 16'h8000, 4'h0, 16'h7FFF, 4'b0001, 4'b0001};
    vecs[2]  = '{0, 4'h4, 16'h00F0, 16'h000F, 4'h0, 16'h00FF, 4'b0000, 4'b0001};
    vecs[3]  = '{1, 4'h5, 16'h0005, 16'h0005, 4'h0, 16'h0000, 4'b0100, 4'b0100};
    vecs[4]  = '{0, 4'h0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'b0110, 4'b0110};
    vecs[5]  = '{0, 4'h4, 16'h00FF, 16'h00FF, 4'h0, 16'h0000, 4'b0100, 4'b0110};
    vecs[6]  = '{1, 4'h6, 16'h1234, 16'h8000, 4'h0, 16'h8000, 4'b1000, 4'b1010};
    vecs[7]  = '{0, 4'h8, 16'h4001, 16'h0000, 4'h1, 16'h8002, 4'b1000, 4'b1010};
    vecs[8]  = '{0, 4'h9, 16'h8000, 16'h0000, 4'hF, 16'h0001, 4'b0000, 4'b0010};
    vecs[9]  = '{1, 4'hC, 16'h0001, 16'h0002, 4'h3, 16'h0000, 4'b0000, 4'b0010};
    vecs[10] = '{0, 4'h7, 16'h0011, 16'h0022, 4'h0, 16'h0000, 4'b0000, 4'b0010};
    vecs[11] = '{0, 4'h1, 16'h0002, 16'h0001, 4'h0, 16'hFFFF, 4'b1010, 4'b1010};

    // Reset: handshakes suppressed during rst, registers cleared after.
    repeat (2) @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    @(negedge clk);
    req_valid = 2'b00; rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_flags", flags, 4'h0);
    check("rst_rsp_res", rsp_res, 16'h0);
    check("rst_rsp_szcv", rsp_szcv, 4'h0);
    check("rst_alu_op", alu_op, 4'h0);
    check("rst_alu_a", alu_a, 16'h0);
    check("rst_alu_b", alu_b, 16'h0);
    check("rst_alu_d", alu_shift_d, 4'h0);
    check("rst_req_ready_idle", req_ready, 2'b00);

    for (int i = 0; i < 12; i++) apply_one(vecs[i]);

    // Response stall: owner holds rsp_ready low for 5 RESP cycles.
    @(negedge clk);
    r.op = 4'h0; r.a = 16'h0003; r.b = 16'h0004; r.d = 4'h0;
    drive_slot(0, r);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1 check("stall_accept0", req_ready, 2'b01);
    @(negedge clk);
    r.op = 4'h1; r.a = 16'h0001; r.b = 16'h8000; r.d = 4'h0;
    drive_slot(1, r);
    drive_slot(0, junk());
    req_valid = 2'b10;
    #1 check("stall_exec_ready", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_ready = 2'b10;
      #1;
      check("stall_rsp_valid", rsp_valid, 2'b01);
      check("stall_rsp_res", rsp_res, 16'h0007);
      check("stall_req_ready", req_ready, 2'b00);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    #1;
    check("stall_release_valid", rsp_valid, 2'b01);
    check("stall_release_ready", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b11;
    #1 check("stall_accept1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("stall_r1_valid", rsp_valid, 2'b10);
    check("stall_r1_res", rsp_res, 16'h7FFF);
    check("stall_r1_flags", flags, 4'b0001);
    @(negedge clk);

    // Reset during EXEC drops the transaction and clears committed flags.
    apply_one('{0, 4'h0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'b0110, 4'b0110});
    @(negedge clk);
    r.op = 4'h0; r.a = 16'h0003; r.b = 16'h0004; r.d = 4'h0;
    drive_slot(0, r);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1 check("rstx_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00; rst = 1'b1;
    #1 check("rstx_exec_valid", rsp_valid, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstx_busy", busy, 1'b0);
    check("rstx_rsp_valid", rsp_valid, 2'b00);
    check("rstx_flags", flags, 4'h0);
    check("rstx_rsp_res", rsp_res, 16'h0);
    @(negedge clk);
    #1 check("rstx_no_late_rsp", rsp_valid, 2'b00);
    apply_one('{0, 4'h0, 16'h0003, 16'h0004, 4'h0, 16'h0007, 4'b0000, 4'b0000});

    // Contention: four ops per requester, both valid from the start.
    do_reset(2);
    m_last = 1; m_flags = 4'h0;
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      r.op = 4'h0; r.a = 16'(i); r.b = 16'h0010; r.d = 4'h0; q0.push_back(r);
      r.op = 4'h1; r.a = 16'(i); r.b = 16'h0100; r.d = 4'h0; q1.push_back(r);
    end
    run_engine(1'b0, 200);
    check("rr_count", glog.size(), 8);
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("rr_order", (i < glog.size()) ? glog[i] : -1, (i < 4) ? 0 : 1);
`else
      check("rr_order", (i < glog.size()) ? glog[i] : -1, i % 2);
`endif
    end

    // Randomized traffic with random response back-pressure.
    do_reset(2);
    m_last = 1; m_flags = 4'h0;
    for (int i = 0; i < 40; i++) q0.push_back(junk());
    for (int i = 0; i < 25; i++) q1.push_back(junk());
    run_engine(1'b1, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
